load_store_unit: RTL and testbench

- Consumes the `tMemOp` strobe emitted by the execute stage and runs the matching data-memory bus transaction.
- Stores: generates byte enables, then retires on grant.
- Loads: waits for read data, aligns and extends it per `funct3`, then returns a `tRegOp` writeback.
- Sits between execute and the register-file writeback mux.
- Holds one outstanding transaction; back-pressures the pipeline with `oBusy`.

---
 rtl/load_store_unit_pkg.sv | 83 ++++++++
 rtl/load_store_unit_load_align.sv | 32 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared core types for the load/store unit: memory-op strobe, register writeback,
// bus request bundle, LSU state encoding and funct3 decode helpers.
package corePckg;

  localparam int cXLEN = 32;

  typedef struct packed {
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [4:0]       rdAddr;
    logic [2:0]       opType;
    logic             read;
    logic             write;
  } tMemOp;

  typedef struct packed {
    logic [4:0]       addr;
    logic [cXLEN-1:0] data;
    logic             dv;
  } tRegOp;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [cXLEN-1:0] addr;
    logic [3:0]       be;
    logic [cXLEN-1:0] wdata;
  } tMemBus;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_REQ      = 2'd1,
    LSU_WAIT_RSP = 2'd2,
    LSU_WB       = 2'd3
  } tLsuState;

  localparam logic [2:0] cLB  = 3'b000;
  localparam logic [2:0] cLH  = 3'b001;
  localparam logic [2:0] cLW  = 3'b010;
  localparam logic [2:0] cLBU = 3'b100;
  localparam logic [2:0] cLHU = 3'b101;
  localparam logic [2:0] cSB  = 3'b000;
  localparam logic [2:0] cSH  = 3'b001;
  localparam logic [2:0] cSW  = 3'b010;

  // Illegal funct3 values are folded into the alignment check so both are dropped alike.
  function automatic logic lsu_op_ok(input logic [2:0] f3, input logic is_store,
                                     input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      cLB:     ok = 1'b1;
      cLH:     ok = !lo[0];
      cLW:     ok = (lo == 2'b00);
      cLBU:    ok = !is_store;
      cLHU:    ok = !is_store && !lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      cSB:     be = 4'b0001 << lo;
      cSH:     be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [cXLEN-1:0] lsu_store_data(input logic [2:0] f3,
                                                      input logic [cXLEN-1:0] d);
    logic [cXLEN-1:0] w;
    case (f3)
      cSB:     w = {4{d[7:0]}};
      cSH:     w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
  import corePckg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr,
  input  logic [cXLEN-1:0] rdata,
  output logic [cXLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      cLB:     data = {{24{byte_lane[7]}}, byte_lane};
      cLH:     data = {{16{half_lane[15]}}, half_lane};
      cLBU:    data = {24'd0, byte_lane};
      cLHU:    data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: turns an execute-stage strobe into one data-bus
// transaction and returns aligned load data as a register writeback.
module load_store_unit
  import corePckg::*;
#(
  parameter int pTimeout = 64,
  parameter int pCntW    = $clog2(pTimeout + 1)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  tMemOp            iMemOp,
  output logic             oBusy,
  output logic             oMemReq,
  input  logic             iMemGnt,
  output logic             oMemWe,
  output logic [cXLEN-1:0] oMemAddr,
  output logic [3:0]       oMemBe,
  output logic [cXLEN-1:0] oMemWData,
  input  logic             iMemRValid,
  input  logic [cXLEN-1:0] iMemRData,
  output tRegOp            oRegWB,
  output logic             oMisaligned,
  output logic             oBusErr,
  output logic             oOverrun,
  output tLsuState         oState
);

  tLsuState         state;
  tMemBus           bus;
  logic [pCntW-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [4:0]       rd_q;
  logic [cXLEN-1:0] aligned;
  logic             strobe;

  assign strobe = iMemOp.read | iMemOp.write;

  lsu_load_align u_align (
    .funct3 (f3_q),
    .addr   (lane_q),
    .rdata  (iMemRData),
    .data   (aligned)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= LSU_IDLE;
      bus         <= '0;
      cnt         <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      rd_q        <= '0;
      oRegWB      <= '0;
      oMisaligned <= 1'b0;
      oBusErr     <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      oMisaligned <= 1'b0;
      oBusErr     <= 1'b0;
      oOverrun    <= 1'b0;
      oRegWB.dv   <= 1'b0;
      if (strobe && state != LSU_IDLE) oOverrun <= 1'b1;

      case (state)
        LSU_IDLE: begin
          if (strobe) begin
            if (!lsu_op_ok(iMemOp.opType, iMemOp.write, iMemOp.addr[1:0])) begin
              oMisaligned <= 1'b1;
            end else begin
              f3_q      <= iMemOp.opType;
              lane_q    <= iMemOp.addr[1:0];
              rd_q      <= iMemOp.rdAddr;
              bus.req   <= 1'b1;
              bus.we    <= iMemOp.write;
              bus.addr  <= {iMemOp.addr[cXLEN-1:2], 2'b00};
              bus.be    <= iMemOp.write ? lsu_store_be(iMemOp.opType, iMemOp.addr[1:0])
                                        : 4'b1111;
              bus.wdata <= iMemOp.write ? lsu_store_data(iMemOp.opType, iMemOp.data)
                                        : '0;
              state     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (iMemGnt) begin
            bus.req <= 1'b0;
            bus.we  <= 1'b0;
            if (bus.we) begin
              state <= LSU_IDLE;
            end else begin
              cnt   <= '0;
              state <= LSU_WAIT_RSP;
            end
          end
        end
        LSU_WAIT_RSP: begin
          // Data arriving on the final allowed cycle still wins over the timeout.
          if (iMemRValid) begin
            oRegWB.addr <= rd_q;
            oRegWB.data <= aligned;
            oRegWB.dv   <= (rd_q != 5'd0);
            state       <= LSU_WB;
          end else if (cnt == pCntW'(pTimeout)) begin
            oBusErr <= 1'b1;
            state   <= LSU_IDLE;
          end else begin
            cnt <= cnt + pCntW'(1);
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign oBusy     = (state != LSU_IDLE);
  assign oState    = state;
  assign oMemReq   = bus.req;
  assign oMemWe    = bus.we;
  assign oMemAddr  = bus.addr;
  assign oMemBe    = bus.be;
  assign oMemWData = bus.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single ops plus hand-written
// sequences for grant stall, overrun, timeout and reset mid-transaction.
module tb_load_store_unit;
  import corePckg::*;

  localparam int TO = 8;

  logic        iClk = 1'b0;
  logic        iRst;
  tMemOp       mem_op;
  logic        oBusy, oMemReq, iMemGnt, oMemWe;
  logic [31:0] oMemAddr, oMemWData, iMemRData;
  logic [3:0]  oMemBe;
  logic        iMemRValid;
  tRegOp       oRegWB;
  logic        oMisaligned, oBusErr, oOverrun;
  tLsuState    oState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.pTimeout(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iMemOp(mem_op), .oBusy(oBusy), .oMemReq(oMemReq),
    .iMemGnt(iMemGnt), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWData(oMemWData), .iMemRValid(iMemRValid), .iMemRData(iMemRData),
    .oRegWB(oRegWB), .oMisaligned(oMisaligned), .oBusErr(oBusErr),
    .oOverrun(oOverrun), .oState(oState)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        bad;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                        input logic wr, input logic [4:0] rd);
    mem_op.addr   = addr;
    mem_op.data   = data;
    mem_op.opType = f3;
    mem_op.rdAddr = rd;
    mem_op.write  = wr;
    mem_op.read   = !wr;
    step();
    mem_op.read  = 1'b0;
    mem_op.write = 1'b0;
  endtask

  task automatic grant();
    iMemGnt = 1'b1;
    step();
    iMemGnt = 1'b0;
  endtask

  task automatic rvalid(input logic [31:0] d);
    iMemRValid = 1'b1;
    iMemRData  = d;
    step();
    iMemRValid = 1'b0;
    iMemRData  = 32'h0;
  endtask

  task automatic check_wb(input string name, input logic [4:0] rd);
    logic [31:0] e;
    if (rd == 5'd0) begin
      check({name, "_dv_x0"}, oRegWB.dv, 1'b0);
    end else begin
      check({name, "_dv"}, oRegWB.dv, 1'b1);
      check({name, "_rd"}, oRegWB.addr, rd);
      if (exp_q.size() == 0) begin
        check({name, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({name, "_wdata"}, oRegWB.data, e);
      end
    end
  endtask

  initial begin
    int first_err;
    int err_pulses;

    vecs[0]  = '{32'h0000_1003, 32'h0, cLB,  1'b0, 5'd5,  32'h80FF_FFFF, 1'b0, 32'h0000_1000, 4'b1111, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{32'h0000_1001, 32'h0, cLBU, 1'b0, 5'd6,  32'h1234_5678, 1'b0, 32'h0000_1000, 4'b1111, 32'h0, 32'h0000_0056};
    vecs[2]  = '{32'h0000_2002, 32'h0, cLH,  1'b0, 5'd7,  32'hBEEF_0000, 1'b0, 32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_BEEF};
    vecs[3]  = '{32'h0000_2000, 32'h0, cLHU, 1'b0, 5'd8,  32'h0000_8001, 1'b0, 32'h0000_2000, 4'b1111, 32'h0, 32'h0000_8001};
    vecs[4]  = '{32'h0000_3004, 32'h0, cLW,  1'b0, 5'd9,  32'hDEAD_BEEF, 1'b0, 32'h0000_3004, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    vecs[5]  = '{32'h0000_0011, 32'h0, cLBU, 1'b0, 5'd0,  32'h0000_FF00, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 32'h0000_00FF};
    vecs[6]  = '{32'h0000_4002, 32'h0000_00A5, cSB, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0000_4000, 4'b0100, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{32'h0000_2002, 32'h0000_ABCD, cSH, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[8]  = '{32'h0000_5000, 32'h1122_3344, cSW, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0000_5000, 4'b1111, 32'h1122_3344, 32'h0};
    vecs[9]  = '{32'h0000_2000, 32'hFFFF_1234, cSH, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0000_2000, 4'b0011, 32'h1234_1234, 32'h0};
    vecs[10] = '{32'h0000_3001, 32'h0, cLW,    1'b0, 5'd4, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
    vecs[11] = '{32'h0000_3001, 32'h0, cLH,    1'b0, 5'd4, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
    vecs[12] = '{32'h0000_3002, 32'h0, cSW,    1'b1, 5'd0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
    vecs[13] = '{32'h0000_3000, 32'h0, 3'b011, 1'b0, 5'd4, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
    vecs[14] = '{32'h0000_3000, 32'h0, 3'b100, 1'b1, 5'd0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};

    // Clock/reset
    mem_op     = '0;
    iMemGnt    = 1'b0;
    iMemRValid = 1'b0;
    iMemRData  = 32'h0;
    iRst       = 1'b1;
    step();
    step();
    iRst = 1'b0;
    check("rst_busy", oBusy, 1'b0);
    check("rst_req", oMemReq, 1'b0);
    check("rst_regwb", {oRegWB.addr, oRegWB.dv}, 6'd0);
    check("rst_state", oState, LSU_IDLE);

    // Table-driven single operations
    for (int i = 0; i < 15; i++) begin
      strobe(vecs[i].addr, vecs[i].data, vecs[i].f3, vecs[i].wr, vecs[i].rd);
      if (vecs[i].bad) begin
        check($sformatf("v%0d_misaligned", i), oMisaligned, 1'b1);
        check($sformatf("v%0d_noreq", i), oMemReq, 1'b0);
        check($sformatf("v%0d_idle", i), oBusy, 1'b0);
        step();
        check($sformatf("v%0d_mis_pulse", i), oMisaligned, 1'b0);
      end else begin
        check($sformatf("v%0d_req", i), oMemReq, 1'b1);
        check($sformatf("v%0d_addr", i), oMemAddr, vecs[i].exp_addr);
        check($sformatf("v%0d_we", i), oMemWe, vecs[i].wr);
        if (vecs[i].wr) begin
          check($sformatf("v%0d_be", i), oMemBe, vecs[i].exp_be);
          check($sformatf("v%0d_wdata", i), oMemWData, vecs[i].exp_wdata);
          grant();
          check($sformatf("v%0d_st_done", i), {oBusy, oMemReq}, 2'b00);
        end else begin
          grant();
          check($sformatf("v%0d_wait", i), oState, LSU_WAIT_RSP);
          if (vecs[i].rd != 5'd0) exp_q.push_back(vecs[i].exp_wb);
          rvalid(vecs[i].rdata);
          check_wb($sformatf("v%0d", i), vecs[i].rd);
          step();
          check($sformatf("v%0d_dv_pulse", i), oRegWB.dv, 1'b0);
          check($sformatf("v%0d_ld_done", i), oBusy, 1'b0);
        end
      end
    end

    // Grant withheld, stray rvalid during REQ, delayed response
    strobe(32'h0000_6008, 32'h0, cLW, 1'b0, 5'd10);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_req", c), oMemReq, 1'b1);
      check($sformatf("stall%0d_addr", c), oMemAddr, 32'h0000_6008);
      check($sformatf("stall%0d_we_busy", c), {oMemWe, oBusy}, 2'b01);
      iMemRValid = (c == 2);
      iMemRData  = 32'h5555_5555;
      step();
      iMemRValid = 1'b0;
    end
    check("stall_still_req", oState, LSU_REQ);
    grant();
    for (int c = 0; c < 3; c++) begin
      iMemGnt = 1'b1;
      check($sformatf("rsp_wait%0d_dv", c), oRegWB.dv, 1'b0);
      check($sformatf("rsp_wait%0d_busy", c), oBusy, 1'b1);
      step();
    end
    iMemGnt = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    rvalid(32'hCAFE_F00D);
    check_wb("stall", 5'd10);
    step();
    check("stall_done", {oBusy, oRegWB.dv}, 2'b00);

    // Strobe during REQ is dropped; the held store completes untouched
    strobe(32'h0000_7000, 32'h55AA_55AA, cSW, 1'b1, 5'd0);
    strobe(32'h0000_8000, 32'h0, cLW, 1'b0, 5'd11);
    check("ovr_pulse", oOverrun, 1'b1);
    check("ovr_addr", oMemAddr, 32'h0000_7000);
    check("ovr_wdata", oMemWData, 32'h55AA_55AA);
    check("ovr_req_we", {oMemReq, oMemWe}, 2'b11);
    grant();
    check("ovr_clear", oOverrun, 1'b0);
    check("ovr_done", oState, LSU_IDLE);

    // Load never answered: one bus-error pulse, no writeback
    strobe(32'h0000_9000, 32'h0, cLW, 1'b0, 5'd12);
    grant();
    first_err  = -1;
    err_pulses = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (oBusErr) begin
        err_pulses++;
        if (first_err < 0) first_err = c;
      end
      check($sformatf("to%0d_nodv", c), oRegWB.dv, 1'b0);
    end
    check("to_cycle", first_err, 32'd9);
    check("to_pulses", err_pulses, 32'd1);
    check("to_idle", {oBusy, oState}, {1'b0, LSU_IDLE});

    // Reset while waiting for read data
    strobe(32'h0000_A000, 32'h0, cLW, 1'b0, 5'd3);
    grant();
    check("rstw_wait", oState, LSU_WAIT_RSP);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    check("rstw_state", oState, LSU_IDLE);
    check("rstw_busy", oBusy, 1'b0);
    check("rstw_bus", {oMemReq, oMemWe, oMemBe}, 6'd0);
    check("rstw_addr", oMemAddr, 32'h0);
    check("rstw_wdata", oMemWData, 32'h0);
    check("rstw_wbdata", oRegWB.data, 32'h0);
    check("rstw_wb", {oRegWB.addr, oRegWB.dv}, 6'd0);
    check("rstw_pulses", {oMisaligned, oBusErr, oOverrun}, 3'd0);
    rvalid(32'h1234_5678);
    check("rstw_no_dv", oRegWB.dv, 1'b0);
    check("rstw_stay_idle", oState, LSU_IDLE);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
